// File: rtl/stream_rr_packet_arbiter.sv
// rtl/stream_rr_packet_arbiter.sv - round-robin fixed-length packet arbiter feeding one streaming FIFO
//
// Ports:
//   ap_clk, ap_rst_n   clock (rising edge), asynchronous active-low reset
//   in_V_V_*           N_IN packed producer streams, stream i at [i*WIDTH +: WIDTH]
//   out_V_V_*          merged stream into the FIFO input port
//   fifo_count         FIFO occupancy in beats, only looked at while idle
//   grant              one-hot owner of the current packet, zero while idle
//   busy               high while a packet burst is in progress
module stream_rr_packet_arbiter #(
  parameter int N_IN    = 2,
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 16,
  parameter int CNT_W   = 14,
  parameter int THRESH  = 16368
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [N_IN*WIDTH-1:0] in_V_V_TDATA,
  input  logic [N_IN-1:0]       in_V_V_TVALID,
  output logic [N_IN-1:0]       in_V_V_TREADY,
  output logic [WIDTH-1:0]      out_V_V_TDATA,
  output logic                  out_V_V_TVALID,
  input  logic                  out_V_V_TREADY,
  input  logic [CNT_W-1:0]      fifo_count,
  output logic [N_IN-1:0]       grant,
  output logic                  busy
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int BC_W  = $clog2(PKT_LEN + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  // Assertion passes straight through; release is retimed to ap_clk so every
  // state flop leaves reset on the same edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  logic [0:0]       state;
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W-1:0] g_idx;
  logic [BC_W-1:0]  beat_cnt;

  logic [N_IN-1:0]  next_grant;
  logic [PTR_W-1:0] sel_idx;
  logic             sel_found;
  logic [PTR_W-1:0] scan_idx;
  logic             beat_hs;

  // Round-robin pick: scan from the stream after the previous owner, wrapping,
  // so the previous owner is the last candidate considered.
  always_comb begin
    next_grant = '0;
    sel_idx    = '0;
    sel_found  = 1'b0;
    scan_idx   = '0;
    for (int k = 1; k <= N_IN; k++) begin
      scan_idx = PTR_W'((int'(last_ptr) + k) % N_IN);
      if (!sel_found && in_V_V_TVALID[scan_idx]) begin
        next_grant[scan_idx] = 1'b1;
        sel_idx              = scan_idx;
        sel_found            = 1'b1;
      end
    end
  end

  assign busy           = (state == S_BURST);
  assign out_V_V_TDATA  = in_V_V_TDATA[g_idx*WIDTH +: WIDTH];
  assign out_V_V_TVALID = busy & in_V_V_TVALID[g_idx];
  // grant is zero outside a burst, so this also keeps every ready low while idle.
  assign in_V_V_TREADY  = grant & {N_IN{out_V_V_TREADY}};
  assign beat_hs        = out_V_V_TVALID & out_V_V_TREADY;

  always_ff @(posedge ap_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= S_IDLE;
      grant    <= '0;
      g_idx    <= '0;
      beat_cnt <= '0;
      last_ptr <= PTR_W'(N_IN - 1);
    end else begin
      case (state)
        S_IDLE: begin
          // Only start a packet when the FIFO can absorb all of it.
          if (sel_found && (fifo_count <= CNT_W'(THRESH))) begin
            grant <= next_grant;
            g_idx <= sel_idx;
            state <= S_BURST;
          end
        end
        default: begin
          if (beat_hs) begin
            if (beat_cnt == BC_W'(PKT_LEN - 1)) begin
              beat_cnt <= '0;
              last_ptr <= g_idx;
              grant    <= '0;
              state    <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_packet_arbiter.sv
// tb/tb_stream_rr_packet_arbiter.sv - self-checking bench for stream_rr_packet_arbiter
module tb_stream_rr_packet_arbiter;

  localparam int N_IN    = 2;
  localparam int WIDTH   = 8;
  localparam int PKT_LEN = 16;
  localparam int CNT_W   = 14;
  localparam int THRESH  = 16368;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst_n;
  logic [N_IN*WIDTH-1:0] in_V_V_TDATA;
  logic [N_IN-1:0]       in_V_V_TVALID;
  logic [N_IN-1:0]       in_V_V_TREADY;
  logic [WIDTH-1:0]      out_V_V_TDATA;
  logic                  out_V_V_TVALID;
  logic                  out_V_V_TREADY;
  logic [CNT_W-1:0]      fifo_count;
  logic [N_IN-1:0]       grant;
  logic                  busy;

  stream_rr_packet_arbiter #(
    .N_IN(N_IN), .WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W), .THRESH(THRESH)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .in_V_V_TDATA(in_V_V_TDATA),
    .in_V_V_TVALID(in_V_V_TVALID),
    .in_V_V_TREADY(in_V_V_TREADY),
    .out_V_V_TDATA(out_V_V_TDATA),
    .out_V_V_TVALID(out_V_V_TVALID),
    .out_V_V_TREADY(out_V_V_TREADY),
    .fifo_count(fifo_count),
    .grant(grant),
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the stream, how many beats it has moved, who
  // finished last, and each producer's next sequence number.
  int m_owner;
  int m_last;
  int m_beats;
  int seq [N_IN];
  int hs_model;
  int hs_dut;

  logic [N_IN-1:0]  cur_v;
  logic             cur_r;
  logic [CNT_W-1:0] cur_cnt;

  typedef struct {
    logic [N_IN-1:0] v;
    logic            r;
    int              cnt;
    int              cycles;
    logic [N_IN-1:0] exp_grant;
    logic            exp_busy;
  } seg_t;

  seg_t segs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] pdata(input int i);
    return WIDTH'((i << 7) | (seq[i] & 127));
  endfunction

  task automatic drive_inputs();
    in_V_V_TVALID  = cur_v;
    out_V_V_TREADY = cur_r;
    fifo_count     = cur_cnt;
    for (int i = 0; i < N_IN; i++) in_V_V_TDATA[i*WIDTH +: WIDTH] = pdata(i);
  endtask

  // One clock: apply inputs at the falling edge, compare just after, then let
  // the model advance to what the next rising edge must produce.
  task automatic cycle_step();
    logic [N_IN-1:0] exp_g;
    logic [N_IN-1:0] exp_rdy;
    logic            exp_v;
    bit              found;
    drive_inputs();
    #1;
    exp_g   = (m_owner >= 0) ? N_IN'(1 << m_owner) : '0;
    exp_v   = (m_owner >= 0) && cur_v[m_owner];
    exp_rdy = (m_owner >= 0 && cur_r) ? N_IN'(1 << m_owner) : '0;
    check("grant", 32'(grant), 32'(exp_g));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("out_tvalid", 32'(out_V_V_TVALID), 32'(exp_v));
    check("in_tready", 32'(in_V_V_TREADY), 32'(exp_rdy));
    if (exp_v) check("out_tdata", 32'(out_V_V_TDATA), 32'(pdata(m_owner)));
    if (out_V_V_TVALID && out_V_V_TREADY) hs_dut++;
    if (m_owner < 0) begin
      found = 0;
      if (cur_v != 0 && cur_cnt <= THRESH) begin
        for (int k = 1; k <= N_IN; k++) begin
          if (!found && cur_v[(m_last + k) % N_IN]) begin
            m_owner = (m_last + k) % N_IN;
            m_beats = 0;
            found   = 1;
          end
        end
      end
    end else if (cur_v[m_owner] && cur_r) begin
      seq[m_owner]++;
      hs_model++;
      m_beats++;
      if (m_beats == PKT_LEN) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N_IN - 1;
    m_beats = 0;
  endtask

  initial begin
    for (int i = 0; i < N_IN; i++) seq[i] = i * 40;
    hs_model = 0;
    hs_dut   = 0;
    model_reset();
    cur_v = '0; cur_r = 1'b0; cur_cnt = '0;
    ap_rst_n = 1'b0;
    drive_inputs();

    // Fixed scenarios: count threshold, mid-burst count rise, alternation, single requester.
    segs[0]  = '{2'b11, 1'b1, 16369, 5,  2'b00, 1'b0};
    segs[1]  = '{2'b11, 1'b1, 16368, 1,  2'b01, 1'b1};
    segs[2]  = '{2'b11, 1'b1, 16383, 16, 2'b00, 1'b0};
    segs[3]  = '{2'b11, 1'b1, 16383, 3,  2'b00, 1'b0};
    segs[4]  = '{2'b11, 1'b1, 0,     1,  2'b10, 1'b1};
    segs[5]  = '{2'b11, 1'b1, 0,     16, 2'b00, 1'b0};
    segs[6]  = '{2'b11, 1'b1, 0,     1,  2'b01, 1'b1};
    segs[7]  = '{2'b11, 1'b1, 0,     16, 2'b00, 1'b0};
    segs[8]  = '{2'b10, 1'b1, 0,     1,  2'b10, 1'b1};
    segs[9]  = '{2'b10, 1'b1, 0,     16, 2'b00, 1'b0};
    segs[10] = '{2'b10, 1'b1, 0,     1,  2'b10, 1'b1};
    segs[11] = '{2'b10, 1'b1, 0,     16, 2'b00, 1'b0};
    segs[12] = '{2'b11, 1'b1, 0,     1,  2'b01, 1'b1};

    repeat (3) @(negedge ap_clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tvalid", 32'(out_V_V_TVALID), 32'h0);
    check("rst_tready", 32'(in_V_V_TREADY), 32'h0);
    ap_rst_n = 1'b1;
    repeat (3) cycle_step();

    for (int s = 0; s < 13; s++) begin
      cur_v   = segs[s].v;
      cur_r   = segs[s].r;
      cur_cnt = CNT_W'(segs[s].cnt);
      repeat (segs[s].cycles) cycle_step();
      check($sformatf("seg%0d_grant", s), 32'(grant), 32'(segs[s].exp_grant));
      check($sformatf("seg%0d_busy", s), 32'(busy), 32'(segs[s].exp_busy));
    end

    // Reset in the middle of stream 0's packet.
    repeat (5) cycle_step();
    ap_rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(out_V_V_TVALID), 32'h0);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_tready", 32'(in_V_V_TREADY), 32'h0);
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge ap_clk);
      #1;
      check("inrst_tvalid", 32'(out_V_V_TVALID), 32'h0);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    cur_v = '0;
    repeat (3) cycle_step();
    cur_v = 2'b11;
    cycle_step();
    check("postrst_grant", 32'(grant), 32'h1);

    // Random traffic: producer gaps, 50% backpressure, occasional full FIFO.
    repeat (3000) begin
      for (int i = 0; i < N_IN; i++) cur_v[i] = ($urandom_range(0, 3) != 0);
      cur_r   = 1'($urandom_range(0, 1));
      cur_cnt = ($urandom_range(0, 9) == 0) ? CNT_W'(16369 + $urandom_range(0, 14))
                                            : CNT_W'($urandom_range(0, 16368));
      cycle_step();
    end
    check("handshake_total", 32'(hs_dut), 32'(hs_model));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
